// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer driving register load, increment, bus, ALU and memory strobes.
// Strobes decode from state; memory-wait states raise write/increment strobes only on mem_ack.
module control_sequencer #(
  parameter int REG_N = 8,
  parameter int OPW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [OPW-1:0]   ir_opcode,
  input  logic             z_flag,
  input  logic             mem_ack,
  output logic             LDIR,
  output logic             dr_read,
  output logic [REG_N-1:0] reg_we,
  output logic [REG_N-1:0] reg_inc,
  output logic [2:0]       bus_sel,
  output logic [1:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state_dbg
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,  F1   = 4'd1,  F2  = 4'd2,  F3   = 4'd3,
    DEC  = 4'd4,  O1   = 4'd5,  O2  = 4'd6,  O3   = 4'd7,
    MRD  = 4'd8,  MRD2 = 4'd9,  MWR = 4'd10, MWR2 = 4'd11,
    JMP  = 4'd12, EXA  = 4'd13, HALT = 4'd14
  } state_t;

  localparam int PC = 0;
  localparam int AR = 1;
  localparam int DR = 2;
  localparam int AC = 3;
  localparam int R1 = 4;

  localparam logic [2:0] B_PC = 3'd0;
  localparam logic [2:0] B_DR = 3'd2;
  localparam logic [2:0] B_AC = 3'd3;

  localparam logic [1:0] ALU_PASS = 2'd0;
  localparam logic [1:0] ALU_ADD  = 2'd1;
  localparam logic [1:0] ALU_SUB  = 2'd2;
  localparam logic [1:0] ALU_CLR  = 2'd3;

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_LOAD  = OPW'(1);
  localparam logic [OPW-1:0] OP_STORE = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
  localparam logic [OPW-1:0] OP_INCAC = OPW'(5);
  localparam logic [OPW-1:0] OP_JUMP  = OPW'(6);
  localparam logic [OPW-1:0] OP_JMPZ  = OPW'(7);
  localparam logic [OPW-1:0] OP_MOVR1 = OPW'(8);
  localparam logic [OPW-1:0] OP_CLAC  = OPW'(9);
  localparam logic [OPW-1:0] OP_HALT  = OPW'(63);

  state_t state;
  logic   illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= F1;
        F1:   state <= F2;
        F2:   if (mem_ack) state <= F3;
        F3:   state <= DEC;
        DEC: begin
          case (ir_opcode)
            OP_NOP:                     state <= F1;
            OP_LOAD, OP_STORE, OP_JUMP: state <= O1;
            OP_JMPZ:                    state <= z_flag ? O1 : F1;
            OP_ADD, OP_SUB, OP_INCAC,
            OP_MOVR1, OP_CLAC:          state <= EXA;
            OP_HALT:                    state <= HALT;
            default: begin
              state     <= HALT;
              illegal_q <= 1'b1;
            end
          endcase
        end
        O1: state <= O2;
        O2: if (mem_ack) state <= (ir_opcode == OP_JUMP || ir_opcode == OP_JMPZ) ? JMP : O3;
        O3: state <= (ir_opcode == OP_LOAD) ? MRD : MWR;
        MRD:  if (mem_ack) state <= MRD2;
        MRD2: state <= F1;
        MWR:  state <= MWR2;
        MWR2: if (mem_ack) state <= F1;
        JMP:  state <= F1;
        EXA:  state <= F1;
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    LDIR      = 1'b0;
    dr_read   = 1'b0;
    reg_we    = '0;
    reg_inc   = '0;
    bus_sel   = B_PC;
    alu_op    = ALU_PASS;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state)
      F1, O1: begin
        bus_sel    = B_PC;
        reg_we[AR] = 1'b1;
      end
      F2, O2: begin
        mem_read = 1'b1;
        dr_read  = 1'b1;
        if (mem_ack) begin
          reg_we[DR]  = 1'b1;
          reg_inc[PC] = 1'b1;
        end
      end
      F3: LDIR = 1'b1;
      // A not-taken JMPZ steps PC over its operand word.
      DEC: if (ir_opcode == OP_JMPZ && !z_flag) reg_inc[PC] = 1'b1;
      O3: begin
        bus_sel    = B_DR;
        reg_we[AR] = 1'b1;
      end
      MRD: begin
        mem_read = 1'b1;
        dr_read  = 1'b1;
        if (mem_ack) reg_we[DR] = 1'b1;
      end
      MRD2: begin
        bus_sel    = B_DR;
        reg_we[AC] = 1'b1;
      end
      MWR: begin
        bus_sel    = B_AC;
        reg_we[DR] = 1'b1;
      end
      MWR2: mem_write = 1'b1;
      JMP: begin
        bus_sel    = B_DR;
        reg_we[PC] = 1'b1;
      end
      EXA: begin
        case (ir_opcode)
          OP_ADD: begin
            alu_op     = ALU_ADD;
            reg_we[AC] = 1'b1;
          end
          OP_SUB: begin
            alu_op     = ALU_SUB;
            reg_we[AC] = 1'b1;
          end
          // AC reloads itself through PASS while its own incrementer adds one.
          OP_INCAC: begin
            bus_sel     = B_AC;
            reg_we[AC]  = 1'b1;
            reg_inc[AC] = 1'b1;
          end
          OP_MOVR1: begin
            bus_sel    = B_AC;
            reg_we[R1] = 1'b1;
          end
          OP_CLAC: begin
            alu_op     = ALU_CLR;
            reg_we[AC] = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE) && (state != HALT);
  assign halted    = (state == HALT);
  assign illegal   = illegal_q;
  assign state_dbg = state;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Moore/Mealy FSM that runs fetch–decode–execute over the register file: ins_registor, data_registor, registor_no_inc and registor_with_inc instances.
- Generates LDIR, DR read select, per-register WE/inc strobes, C-bus source select, ALU op and memory read/write handshakes.
- Sits between the memory interface and the datapath; owns all register load and increment timing.

Parameters:
- REG_N, 8, number of datapath registers addressed by reg_we/reg_inc. Fixed indices: PC=0, AR=1, DR=2, AC=3, R1=4; indices 5–7 are spare and held 0.
- OPW, 6, opcode width; equals the IR width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin execution from IDLE
- ir_opcode  in  OPW  current IR contents
- z_flag  in  1  AC==0 flag from datapath
- mem_ack  in  1  memory completes the current read or write this cycle
- LDIR  out  1  IR load strobe
- dr_read  out  1  DR source: 1 = ram_in, 0 = c_bus
- reg_we  out  REG_N  one-hot register write enables
- reg_inc  out  REG_N  increment strobes; only PC is ever driven
- bus_sel  out  3  C-bus source register index (PC/AR/DR/AC/R1)
- alu_op  out  2  0 PASS, 1 ADD (AC+R1), 2 SUB (AC-R1), 3 CLR
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- illegal  out  1  sticky; set when HALT is entered via an undefined opcode
- state_dbg  out  4  current state encoding

Behaviour:
- Reset: async on rst_n=0 → IDLE, illegal=0. All outputs 0 in IDLE except state_dbg=0. Reset mid-handshake abandons the transfer immediately.
- Outputs:
  - Decoded from state; cycles not listed below drive 0.
  - Exceptions: WE/inc strobes in memory-wait states assert only in the cycle mem_ack=1.
  - Datapath registers capture on the same clk edge the FSM advances.
- Encoding: IDLE=0, F1=1, F2=2, F3=3, DEC=4, O1=5, O2=6, O3=7, MRD=8, MRD2=9, MWR=10, MWR2=11, JMP=12, EXA=13, HALT=14.
- IDLE: start=1 → F1; otherwise stay.
- F1: bus_sel=PC, we[AR] → F2.
- F2: mem_read=1, dr_read=1. Stay while mem_ack=0. On ack: we[DR]=1, inc[PC]=1 → F3.
- F3: LDIR=1 → DEC.
- DEC (z_flag sampled here only), opcode map:
  - 0 NOP → F1
  - 1 LOAD, 2 STORE, 6 JUMP → O1
  - 7 JMPZ → O1 if z_flag=1; if z_flag=0, inc[PC]=1 (skip operand word) → F1
  - 3 ADD, 4 SUB, 5 INCAC, 8 MOVR1, 9 CLAC → EXA
  - 63 HALT → HALT
  - any other value → HALT with illegal←1
- O1: bus_sel=PC, we[AR] → O2.
- O2: mem_read, dr_read. Wait for ack. On ack: we[DR], inc[PC]; → JMP for JUMP/JMPZ, else → O3.
- O3: bus_sel=DR, we[AR]; LOAD → MRD, STORE → MWR.
- MRD: mem_read, dr_read. Wait for ack; we[DR] on ack → MRD2.
- MRD2: bus_sel=DR, alu_op=PASS, we[AC] → F1.
- MWR: bus_sel=AC, dr_read=0, we[DR] → MWR2.
- MWR2: mem_write=1 held until ack → F1.
- JMP: bus_sel=DR, we[PC] → F1.
- EXA → F1, one cycle:
  - ADD/SUB: alu_op 1/2, we[AC]
  - INCAC: bus_sel=AC, alu_op=PASS, we[AC], plus 1 applied via the AC adder path; AC is registor_with_inc, so inc[AC] is allowed here as the single exception to the PC-only rule
  - MOVR1: bus_sel=AC, we[R1]
  - CLAC: alu_op=CLR, we[AC]
- HALT: halted=1, busy=0; start ignored; exit only via rst_n.
- Invariants: mem_read and mem_write never both high; at most one reg_we bit high per cycle; PC never both written and incremented in one cycle.
- Latency with zero-wait memory (ack on the first request cycle): NOP 4 cycles, ALU op 5, JUMP 7, LOAD 9, STORE 9.

Test Plan:
- Reset/start: rst_n=0 for 2 cycles, then start=1 → F1 next edge; reg_we=8'b0000_0010, bus_sel=0.
- Fetch with wait: mem_ack low 3 cycles in F2 → mem_read held 4 cycles; we[DR] and inc[PC] pulse exactly once, on the ack cycle; LDIR next cycle.
- LOAD, opcode 1, ack always 1 → state sequence 1,2,3,4,5,6,7,8,9,1; inc[PC] pulses twice; we[AC] in state 9.
- JMPZ, opcode 7: z_flag=0 → DEC asserts inc[PC] and returns to F1; z_flag=1 → states 5,6,12, with we[PC]=1 and bus_sel=DR in state 12.
- STORE, opcode 2, ack delayed 2 cycles in MWR2 → mem_write high 3 cycles, mem_read never high during MWR/MWR2.
- Opcode 6'h2A → HALT with illegal=1, halted=1; start pulses ignored; rst_n low mid-F2 wait → IDLE immediately and all strobes 0.
